dma_scheduler: RTL and testbench

Sequences the S2MM path between the sample stream and the AXI DataMover for the triple/quad-buffer manager. Per burst: issue one DataMover write command for the address the buffer manager currently exposes, pass exactly BURST_LEN beats with TLAST on the final beat, then wait for the DataMover status. Each beat is reported back to the buffer manager so its offset and buffer rotation stay in lock-step with memory. Status errors stop the block until it is cleared.

---
 rtl/dma_scheduler_pkg.sv | 46 ++++
 rtl/dma_scheduler.sv | 133 +++++++++++++
 tb/tb_dma_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_scheduler_pkg.sv
// Shared encodings for the S2MM scheduler: FSM states, DataMover command
// field layout and status bit positions.
package dma_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_DATA  = 3'd2,
    ST_STS   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam int CMD_W         = 72;
  localparam int CMD_BTT_LSB   = 0;
  localparam int CMD_BTT_W     = 23;
  localparam int CMD_TYPE_BIT  = 23;
  localparam int CMD_EOF_BIT   = 30;
  localparam int CMD_SADDR_LSB = 32;
  localparam int CMD_SADDR_W   = 32;
  localparam int CMD_TAG_LSB   = 64;
  localparam int CMD_TAG_W     = 4;

  localparam int STS_OKAY_BIT   = 7;
  localparam int STS_SLVERR_BIT = 6;
  localparam int STS_DECERR_BIT = 5;
  localparam int STS_INTERR_BIT = 4;
  localparam int STS_TAG_LSB    = 0;
  localparam int STS_TAG_W      = 4;

  // INCR transfer with EOF set; every unnamed field stays zero.
  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic [CMD_SADDR_W-1:0] saddr,
    input logic [CMD_BTT_W-1:0]   btt,
    input logic [CMD_TAG_W-1:0]   tag
  );
    logic [CMD_W-1:0] w;
    w = '0;
    w[CMD_BTT_LSB +: CMD_BTT_W]     = btt;
    w[CMD_TYPE_BIT]                 = 1'b1;
    w[CMD_EOF_BIT]                  = 1'b1;
    w[CMD_SADDR_LSB +: CMD_SADDR_W] = saddr;
    w[CMD_TAG_LSB +: CMD_TAG_W]     = tag;
    return w;
  endfunction

endpackage

// File: rtl/dma_scheduler.sv
// S2MM burst sequencer: one DataMover command, BURST_LEN pass-through beats,
// then a tagged status check per burst; status errors park the block in ERROR.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for enable; latches the buffer address on exit
// ST_CMD   | command word presented until the DataMover takes it
// ST_DATA  | stream passes straight through, beats counted
// ST_STS   | waiting for the DataMover status of this burst
// ST_ERROR | bad status seen; everything quiet until clear_error
module dma_scheduler
  import dma_scheduler_pkg::*;
#(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_LEN     = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic                     clear_error,
  input  logic [DATA_WIDTH-1:0]    S_AXIS_tdata,
  input  logic                     S_AXIS_tvalid,
  output logic                     S_AXIS_tready,
  output logic [DATA_WIDTH-1:0]    M_AXIS_S2MM_tdata,
  output logic                     M_AXIS_S2MM_tvalid,
  input  logic                     M_AXIS_S2MM_tready,
  output logic                     M_AXIS_S2MM_tlast,
  output logic [CMD_W-1:0]         M_AXIS_CMD_tdata,
  output logic                     M_AXIS_CMD_tvalid,
  input  logic                     M_AXIS_CMD_tready,
  input  logic [7:0]               S_AXIS_STS_tdata,
  input  logic                     S_AXIS_STS_tvalid,
  output logic                     S_AXIS_STS_tready,
  input  logic [MM_ADDR_WIDTH-1:0] SM_write_buffer,
  output logic                     SM_writing,
  output logic                     SM_burst_done,
  output logic                     error,
  output logic [31:0]              stall_count
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [CMD_BTT_W-1:0] BTT       = CMD_BTT_W'(BURST_LEN * DATA_WIDTH / 8);

  state_t                   state_q, state_d;
  logic [MM_ADDR_WIDTH-1:0] addr_q;
  logic [CMD_TAG_W-1:0]     tag_q;
  logic [BEAT_W-1:0]        beat_cnt;
  logic                     error_q;
  logic [31:0]              stall_q;
  logic                     sts_ok;

  // Command word depends only on flops, so it is stable for the whole CMD state.
  assign M_AXIS_CMD_tdata  = pack_cmd(CMD_SADDR_W'(addr_q), BTT, tag_q);
  assign M_AXIS_S2MM_tdata = S_AXIS_tdata;
  assign error             = error_q;
  assign stall_count       = stall_q;

  assign sts_ok = S_AXIS_STS_tdata[STS_OKAY_BIT]
                & ~S_AXIS_STS_tdata[STS_SLVERR_BIT]
                & ~S_AXIS_STS_tdata[STS_DECERR_BIT]
                & ~S_AXIS_STS_tdata[STS_INTERR_BIT]
                & (S_AXIS_STS_tdata[STS_TAG_LSB +: STS_TAG_W] == tag_q);

  always_comb begin
    state_d            = state_q;
    M_AXIS_CMD_tvalid  = 1'b0;
    M_AXIS_S2MM_tvalid = 1'b0;
    M_AXIS_S2MM_tlast  = 1'b0;
    S_AXIS_tready      = 1'b0;
    S_AXIS_STS_tready  = 1'b0;
    SM_writing         = 1'b0;
    SM_burst_done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_CMD;
      end
      ST_CMD: begin
        M_AXIS_CMD_tvalid = 1'b1;
        if (M_AXIS_CMD_tready) state_d = ST_DATA;
      end
      ST_DATA: begin
        M_AXIS_S2MM_tvalid = S_AXIS_tvalid;
        S_AXIS_tready      = M_AXIS_S2MM_tready;
        M_AXIS_S2MM_tlast  = (beat_cnt == LAST_BEAT);
        SM_writing         = S_AXIS_tvalid & M_AXIS_S2MM_tready;
        if (SM_writing && M_AXIS_S2MM_tlast) state_d = ST_STS;
      end
      ST_STS: begin
        S_AXIS_STS_tready = 1'b1;
        if (S_AXIS_STS_tvalid) begin
          if (sts_ok) begin
            SM_burst_done = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        if (clear_error) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      tag_q    <= '0;
      beat_cnt <= '0;
      error_q  <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == ST_IDLE && enable) addr_q <= SM_write_buffer;

      if (state_q == ST_CMD && M_AXIS_CMD_tready) beat_cnt <= '0;
      else if (SM_writing)                        beat_cnt <= beat_cnt + BEAT_W'(1);

      if (SM_burst_done) tag_q <= tag_q + CMD_TAG_W'(1);

      if (state_q == ST_STS && S_AXIS_STS_tvalid && !sts_ok) error_q <= 1'b1;
      else if (state_q == ST_ERROR && clear_error)           error_q <= 1'b0;

      if (S_AXIS_tvalid && !S_AXIS_tready && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_dma_scheduler.sv
// Directed bench for dma_scheduler: a 16-beat/32-bit instance for the main
// sequences and a 1-beat/64-bit instance for the minimum-period case.
module tb_dma_scheduler;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BL  = 16;
  localparam int DW1 = 64;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic          enable, clear_error;
  logic [DW-1:0] s_tdata, m_tdata;
  logic          s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
  logic [71:0]   cmd_tdata;
  logic          cmd_tvalid, cmd_tready;
  logic [7:0]    sts_tdata;
  logic          sts_tvalid, sts_tready;
  logic [AW-1:0] wbuf;
  logic          sm_writing, sm_done, err;
  logic [31:0]   stall_count;

  logic           enable1, clear_error1;
  logic [DW1-1:0] s1_tdata, m1_tdata;
  logic           s1_tvalid, s1_tready, m1_tvalid, m1_tready, m1_tlast;
  logic [71:0]    cmd1_tdata;
  logic           cmd1_tvalid, cmd1_tready;
  logic [7:0]     sts1_tdata;
  logic           sts1_tvalid, sts1_tready;
  logic [AW-1:0]  wbuf1;
  logic           sm1_writing, sm1_done, err1;
  logic [31:0]    stall1_count;

  dma_scheduler #(.MM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .clear_error(clear_error),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
    .M_AXIS_S2MM_tdata(m_tdata), .M_AXIS_S2MM_tvalid(m_tvalid),
    .M_AXIS_S2MM_tready(m_tready), .M_AXIS_S2MM_tlast(m_tlast),
    .M_AXIS_CMD_tdata(cmd_tdata), .M_AXIS_CMD_tvalid(cmd_tvalid), .M_AXIS_CMD_tready(cmd_tready),
    .S_AXIS_STS_tdata(sts_tdata), .S_AXIS_STS_tvalid(sts_tvalid), .S_AXIS_STS_tready(sts_tready),
    .SM_write_buffer(wbuf), .SM_writing(sm_writing), .SM_burst_done(sm_done),
    .error(err), .stall_count(stall_count)
  );

  dma_scheduler #(.MM_ADDR_WIDTH(AW), .DATA_WIDTH(DW1), .BURST_LEN(1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable1), .clear_error(clear_error1),
    .S_AXIS_tdata(s1_tdata), .S_AXIS_tvalid(s1_tvalid), .S_AXIS_tready(s1_tready),
    .M_AXIS_S2MM_tdata(m1_tdata), .M_AXIS_S2MM_tvalid(m1_tvalid),
    .M_AXIS_S2MM_tready(m1_tready), .M_AXIS_S2MM_tlast(m1_tlast),
    .M_AXIS_CMD_tdata(cmd1_tdata), .M_AXIS_CMD_tvalid(cmd1_tvalid), .M_AXIS_CMD_tready(cmd1_tready),
    .S_AXIS_STS_tdata(sts1_tdata), .S_AXIS_STS_tvalid(sts1_tvalid), .S_AXIS_STS_tready(sts1_tready),
    .SM_write_buffer(wbuf1), .SM_writing(sm1_writing), .SM_burst_done(sm1_done),
    .error(err1), .stall_count(stall1_count)
  );

  int checks = 0;
  int errors = 0;

  // Stream monitor on the 16-beat instance.
  int            hs_cnt = 0, wr_cnt = 0, last_cnt = 0, done_cnt = 0;
  int            tlast_err = 0, data_err = 0, beat_idx = 0;
  longint        stall_model = 0;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] src_val  = '0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      beat_idx    = 0;
      stall_model = 0;
    end else begin
      if (s_tvalid && !s_tready) stall_model++;
      if (sm_writing) wr_cnt++;
      if (sm_done)    done_cnt++;
      if (m_tvalid && m_tready) begin
        hs_cnt++;
        if (m_tdata !== exp_data) data_err++;
        exp_data = exp_data + 1'b1;
        if (m_tlast !== (beat_idx == BL - 1)) tlast_err++;
        if (m_tlast) last_cnt++;
        beat_idx = (beat_idx + 1) % BL;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [71:0] exp_cmd(input logic [31:0] a, input logic [3:0] t,
                                          input logic [22:0] btt);
    return {4'h0, t, a, 8'h40, 1'b1, btt};
  endfunction

  task automatic do_cmd(input logic [31:0] addr, input logic [3:0] tag, input string name);
    int n = 0;
    while (!cmd_tvalid && n < 20) begin
      tick();
      n++;
    end
    check({name, "_cmd_valid"}, 72'(cmd_tvalid), 72'd1);
    check({name, "_cmd_word"}, cmd_tdata, exp_cmd(addr, tag, 23'd64));
    wbuf = addr ^ 32'hFFFF_0000;
    tick();
    check({name, "_cmd_hold"}, cmd_tdata, exp_cmd(addr, tag, 23'd64));
    cmd_tready = 1'b1;
    tick();
    cmd_tready = 1'b0;
    check({name, "_cmd_drop"}, 72'(cmd_tvalid), 72'd0);
  endtask

  task automatic pump(input int beats, input bit gaps, input string name);
    int sent = 0;
    int cyc  = 0;
    bit hs;
    while (sent < beats && cyc < 500) begin
      s_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_tready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_tdata  = src_val;
      #1;
      hs = s_tvalid && s_tready;
      @(posedge aclk);
      #1;
      if (hs) begin
        sent++;
        src_val = src_val + 1'b1;
      end
      cyc++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    check({name, "_beats"}, 72'(sent), 72'(beats));
  endtask

  task automatic do_sts(input logic [7:0] st, input bit exp_done, input string name);
    int n = 0;
    while (!sts_tready && n < 20) begin
      tick();
      n++;
    end
    check({name, "_sts_ready"}, 72'(sts_tready), 72'd1);
    sts_tdata  = st;
    sts_tvalid = 1'b1;
    #1;
    check({name, "_done"}, 72'(sm_done), 72'(exp_done));
    tick();
    sts_tvalid = 1'b0;
  endtask

  initial begin
    int            wr0, last0, hs0;
    int            st0;
    logic [31:0]   a;
    logic [3:0]    tag1;
    int            wr1_n, last1_n, first_wr, prev_wr, gap_bad;

    enable = 0; clear_error = 0; s_tdata = '0; wbuf = '0; sts_tdata = '0;
    s_tvalid = 1; m_tready = 1; cmd_tready = 1; sts_tvalid = 1;
    enable1 = 0; clear_error1 = 0; s1_tdata = 64'hDEAD_BEEF_0000_0001; wbuf1 = 32'h8000_0000;
    s1_tvalid = 0; m1_tready = 0; cmd1_tready = 0; sts1_tvalid = 0; sts1_tdata = '0;

    // Reset values, with all handshake inputs pushing
    repeat (3) tick();
    check("rst_cmd_tvalid", 72'(cmd_tvalid), 72'd0);
    check("rst_s_tready",   72'(s_tready),   72'd0);
    check("rst_m_tvalid",   72'(m_tvalid),   72'd0);
    check("rst_tlast",      72'(m_tlast),    72'd0);
    check("rst_sts_tready", 72'(sts_tready), 72'd0);
    check("rst_writing",    72'(sm_writing), 72'd0);
    check("rst_done",       72'(sm_done),    72'd0);
    check("rst_error",      72'(err),        72'd0);
    check("rst_stall",      72'(stall_count), 72'd0);
    aresetn = 1; s_tvalid = 0; m_tready = 0; cmd_tready = 0; sts_tvalid = 0;
    tick();

    // Single burst at 0x1000_0000
    wbuf = 32'h1000_0000; enable = 1;
    tick();
    check("t1_cmd_literal", cmd_tdata, 72'h00_1000_0000_4080_0040);
    do_cmd(32'h1000_0000, 4'd0, "t1");
    wr0 = wr_cnt; last0 = last_cnt;
    pump(16, 1'b0, "t1");
    check("t1_writes", 72'(wr_cnt - wr0), 72'd16);
    check("t1_tlasts", 72'(last_cnt - last0), 72'd1);
    do_sts(8'h80, 1'b1, "t1");
    check("t1_error", 72'(err), 72'd0);

    // SLVERR status, stall during ERROR, then recovery with tag kept
    wbuf = 32'h2000_0000;
    do_cmd(32'h2000_0000, 4'd1, "t2");
    pump(16, 1'b0, "t2");
    do_sts(8'hC1, 1'b0, "t2");
    check("t2_error_set", 72'(err), 72'd1);
    s_tvalid = 1; m_tready = 1; cmd_tready = 1; sts_tvalid = 1; sts_tdata = 8'h81;
    #1;
    check("t2_err_s_tready",   72'(s_tready),   72'd0);
    check("t2_err_m_tvalid",   72'(m_tvalid),   72'd0);
    check("t2_err_cmd_tvalid", 72'(cmd_tvalid), 72'd0);
    check("t2_err_sts_tready", 72'(sts_tready), 72'd0);
    st0 = int'(stall_count);
    repeat (4) tick();
    check("t2_stall_delta", 72'(int'(stall_count) - st0), 72'd4);
    check("t2_stall_model", 72'(stall_count), 72'(stall_model));
    check("t2_still_error", 72'(err), 72'd1);
    s_tvalid = 0; m_tready = 0; cmd_tready = 0; sts_tvalid = 0;
    wbuf = 32'h3000_0000;
    clear_error = 1;
    tick();
    clear_error = 0;
    check("t2_error_clr", 72'(err), 72'd0);
    do_cmd(32'h3000_0000, 4'd1, "t2r");
    pump(16, 1'b0, "t2r");
    do_sts(8'h81, 1'b1, "t2r");

    // enable dropped at beat 5: burst finishes, then IDLE holds
    wbuf = 32'h4000_0000;
    do_cmd(32'h4000_0000, 4'd2, "t3");
    wr0 = wr_cnt; last0 = last_cnt;
    pump(5, 1'b0, "t3a");
    enable = 0;
    pump(11, 1'b0, "t3b");
    check("t3_writes", 72'(wr_cnt - wr0), 72'd16);
    check("t3_tlasts", 72'(last_cnt - last0), 72'd1);
    do_sts(8'h82, 1'b1, "t3");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_idle_hold", 72'(cmd_tvalid), 72'd0);
    end

    // Async reset at beat 7
    enable = 1; wbuf = 32'h5000_0000;
    do_cmd(32'h5000_0000, 4'd3, "t4");
    pump(7, 1'b0, "t4");
    s_tvalid = 1; m_tready = 1;
    #1;
    check("t4_pre_m_tvalid", 72'(m_tvalid), 72'd1);
    aresetn = 0;
    #1;
    check("t4_rst_m_tvalid", 72'(m_tvalid),   72'd0);
    check("t4_rst_s_tready", 72'(s_tready),   72'd0);
    check("t4_rst_writing",  72'(sm_writing), 72'd0);
    check("t4_rst_tlast",    72'(m_tlast),    72'd0);
    check("t4_rst_stall",    72'(stall_count), 72'd0);
    tick();
    tick();
    s_tvalid = 0; m_tready = 0;
    aresetn = 1;

    // Three bursts with random gaps; tags restart at 0
    wr0 = wr_cnt; hs0 = hs_cnt;
    for (int b = 0; b < 3; b++) begin
      a = 32'h7000_0000 + 32'(b) * 32'h100;
      wbuf = a;
      do_cmd(a, 4'(b), "t5");
      pump(16, 1'b1, "t5");
      do_sts({4'h8, 4'(b)}, 1'b1, "t5");
    end
    check("t5_writes",  72'(wr_cnt - wr0), 72'd48);
    check("t5_beats",   72'(hs_cnt - hs0), 72'd48);
    check("all_data",   72'(data_err),  72'd0);
    check("all_tlast",  72'(tlast_err), 72'd0);
    check("all_stall",  72'(stall_count), 72'(stall_model));

    // BURST_LEN=1, 64-bit: BTT=8, tlast every beat, 4-cycle period
    tag1 = 4'd0; wr1_n = 0; last1_n = 0; first_wr = -1; prev_wr = -1; gap_bad = 0;
    enable1 = 1; cmd1_tready = 1; s1_tvalid = 1; m1_tready = 1; sts1_tvalid = 1;
    for (int c = 0; c < 12; c++) begin
      sts1_tdata = {4'h8, tag1};
      #1;
      if (c == 1) check("t6_cmd_word", cmd1_tdata, 72'h00_8000_0000_4080_0008);
      if (sm1_writing) begin
        wr1_n++;
        if (m1_tlast) last1_n++;
        if (first_wr < 0) first_wr = c;
        else if (c - prev_wr != 4) gap_bad++;
        prev_wr = c;
      end
      if (sm1_done) tag1 = tag1 + 4'd1;
      tick();
    end
    enable1 = 0; s1_tvalid = 0; m1_tready = 0; sts1_tvalid = 0; cmd1_tready = 0;
    check("t6_writes",   72'(wr1_n),    72'd3);
    check("t6_tlasts",   72'(last1_n),  72'd3);
    check("t6_first_wr", 72'(first_wr), 72'd2);
    check("t6_period",   72'(gap_bad),  72'd0);
    check("t6_tag",      72'(tag1),     72'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
